// File: rtl/fp_pkg.sv
// Shared FP32 types and constants for the FMA normalize/round stage.
// Optional feature: FP_FMA_RMM_EN enables round-to-nearest-max-magnitude;
// without it, rounding_mode 4 decodes to RNE and no RMM logic is built.
package fp_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rnd_mode_e;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] frac;
    } fp_32b_t;

    localparam int          FP32_BIAS       = 127;
    localparam int          FP32_EXP_MAX    = 2 * FP32_BIAS + 1;
    localparam logic [30:0] FP32_MAX_FINITE = 31'h7F7F_FFFF;
    localparam logic [30:0] FP32_INF        = 31'h7F80_0000;

    // Reserved encodings (and RMM when not built) fall back to RNE.
    function automatic rnd_mode_e decode_mode(input logic [2:0] rm);
        case (rm)
            3'd1:    return RM_RTZ;
            3'd2:    return RM_RDN;
            3'd3:    return RM_RUP;
`ifdef FP_FMA_RMM_EN
            3'd4:    return RM_RMM;
`endif
            default: return RM_RNE;
        endcase
    endfunction

endpackage

// File: rtl/fp_lzc50.sv
// Combinational 50-bit leading-zero counter; all-zero input yields 50.
module fp_lzc50 (
    input  logic [49:0] value,
    output logic [5:0]  count
);

    // Highest set bit wins because it is visited last.
    always_comb begin
        count = 6'd50;
        for (int i = 0; i < 50; i++) begin
            if (value[i]) count = 6'(49 - i);
        end
    end

endmodule

// File: rtl/fp_fma_normalize_round.sv
// Two-stage FMA back end: S1 normalizes the raw sum, S2 rounds and packs
// into FP32 with IEEE flags. Valid/ready on both sides.
module fp_fma_normalize_round
    import fp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic               special_case,
    input  logic [31:0]        special_result,
    input  logic               input_is_invalid,
    input  logic               input_is_flushed,
    input  logic [2:0]         rounding_mode,
    input  logic               sum_sign,
    input  logic signed [9:0]  sum_exp,
    input  logic [49:0]        sum_mant,
    input  logic               sticky_in,
    output logic [31:0]        out,
    output logic               overflow,
    output logic               underflow,
    output logic               inexact,
    output logic               invalid_operation,
    output logic               valid_out,
    input  logic               out_ready
);

    logic              s2_adv;
    logic [5:0]        lz;
    logic [5:0]        lshift;
    logic [48:0]       n_mant;
    logic signed [11:0] n_exp;
    logic              n_sticky;

    logic              s1_valid, s1_sign, s1_sticky, s1_zero, s1_tiny;
    logic              s1_special, s1_invalid, s1_flushed;
    logic signed [11:0] s1_exp;
    logic [48:0]       s1_mant;
    logic [31:0]       s1_special_result;
    rnd_mode_e         s1_mode;

    logic              guard, sticky, inc;
    logic [23:0]       rounded;
    logic signed [11:0] r_exp;
    logic [30:0]       ovf_mag;
    fp_32b_t           res;
    logic              res_ovf, res_unf, res_inx;

    assign s2_adv    = ~valid_out | out_ready;
    assign ready_out = s2_adv | ~s1_valid;

    fp_lzc50 u_lzc (
        .value (sum_mant),
        .count (lz)
    );

    // S1 combinational normalize: carry shifts right, otherwise left so bit 48 is set.
    always_comb begin
        lshift = lz - 6'd1;
        if (sum_mant[49]) begin
            n_mant   = sum_mant[49:1];
            n_exp    = 12'(sum_exp) + 12'sd1;
            n_sticky = sticky_in | sum_mant[0];
        end else begin
            n_mant   = sum_mant[48:0] << lshift;
            n_exp    = 12'(sum_exp) - $signed({6'd0, lshift});
            n_sticky = sticky_in;
        end
    end

    // S1 register: loads whenever the stage can accept, holds while blocked.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid          <= 1'b0;
            s1_sign           <= 1'b0;
            s1_exp            <= '0;
            s1_mant           <= '0;
            s1_sticky         <= 1'b0;
            s1_zero           <= 1'b0;
            s1_tiny           <= 1'b0;
            s1_mode           <= RM_RNE;
            s1_special        <= 1'b0;
            s1_special_result <= '0;
            s1_invalid        <= 1'b0;
            s1_flushed        <= 1'b0;
        end else if (ready_out) begin
            s1_valid          <= valid_in;
            s1_sign           <= sum_sign;
            s1_exp            <= n_exp;
            s1_mant           <= n_mant;
            s1_sticky         <= n_sticky;
            s1_zero           <= (sum_mant == '0) & ~sticky_in;
            s1_tiny           <= (sum_mant == '0) & sticky_in;
            s1_mode           <= decode_mode(rounding_mode);
            s1_special        <= special_case;
            s1_special_result <= special_result;
            s1_invalid        <= input_is_invalid;
            s1_flushed        <= input_is_flushed;
        end
    end

    // S2 combinational round, range check and pack.
    always_comb begin
        guard  = s1_mant[24];
        sticky = (|s1_mant[23:0]) | s1_sticky;
        case (s1_mode)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = (guard | sticky) & s1_sign;
            RM_RUP:  inc = (guard | sticky) & ~s1_sign;
`ifdef FP_FMA_RMM_EN
            RM_RMM:  inc = guard;
`endif
            default: inc = guard & (sticky | s1_mant[25]);
        endcase
        // A carry out leaves the fraction field at zero by itself.
        rounded = {1'b0, s1_mant[47:25]} + {23'd0, inc};
        r_exp   = s1_exp + $signed({11'd0, rounded[23]});

        case (s1_mode)
            RM_RTZ:  ovf_mag = FP32_MAX_FINITE;
            RM_RDN:  ovf_mag = s1_sign ? FP32_INF : FP32_MAX_FINITE;
            RM_RUP:  ovf_mag = s1_sign ? FP32_MAX_FINITE : FP32_INF;
            default: ovf_mag = FP32_INF;
        endcase

        res     = '0;
        res_ovf = 1'b0;
        res_unf = 1'b0;
        res_inx = 1'b0;
        if (s1_special) begin
            res = fp_32b_t'(s1_special_result);
        end else if (s1_zero) begin
            res.sign = (s1_mode == RM_RDN);
            res_inx  = s1_flushed;
        end else if (s1_tiny || r_exp <= 12'sd0) begin
            res.sign = s1_sign;
            res_unf  = 1'b1;
            res_inx  = 1'b1;
        end else if (r_exp >= $signed(12'(FP32_EXP_MAX))) begin
            res      = fp_32b_t'({s1_sign, ovf_mag});
            res_ovf  = 1'b1;
            res_inx  = 1'b1;
        end else begin
            res.sign = s1_sign;
            res.exp  = r_exp[7:0];
            res.frac = rounded[22:0];
            res_inx  = guard | sticky | s1_flushed;
        end
    end

    // Output register: updates only when empty or retiring, so results hold under stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_out         <= 1'b0;
            out               <= '0;
            overflow          <= 1'b0;
            underflow         <= 1'b0;
            inexact           <= 1'b0;
            invalid_operation <= 1'b0;
        end else if (s2_adv) begin
            valid_out         <= s1_valid;
            out               <= res;
            overflow          <= res_ovf;
            underflow         <= res_unf;
            inexact           <= res_inx;
            invalid_operation <= s1_invalid;
        end
    end

endmodule
